systolic_array_ctrl: RTL

Parametrised load/compute sequencer for the systolic array. It accepts row data on a valid/ready stream and writes it into the array register file through the IDX/WRITE/DIN port set. It then holds WRITE for the pipeline-fill cycles and runs the matmul window for a fixed number of cycles before pulsing DONE. It replaces hand-sequenced stimulus with a generalised controller: configurable lane count, data width, row depth and cycle budgets, plus a start/abort handshake and back-pressure.

---
 rtl/systolic_array_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/systolic_array_ctrl.sv
// Load/compute sequencer for the systolic array: streams rows into the array RF,
// holds WRITE for pipeline fill, runs a fixed compute window, then pulses DONE.
module systolic_array_ctrl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LANES       = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned FILL_CYC    = 2,
  parameter int unsigned COMPUTE_CYC = 30
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic                      ABORT,
  input  logic [IDX_W-1:0]          NUM_ROWS,
  input  logic                      S_VALID,
  output logic                      S_READY,
  input  logic [LANES*DATA_W-1:0]   S_DATA,
  output logic                      SA_EN,
  output logic                      SA_RF_EN,
  output logic                      SA_WRITE,
  output logic [IDX_W-1:0]          SA_IDX,
  output logic [LANES*DATA_W-1:0]   SA_DIN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [IDX_W:0]            ROWS_LOADED
);

  localparam int unsigned MaxCyc = (FILL_CYC > COMPUTE_CYC) ? FILL_CYC : COMPUTE_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned DinW   = LANES * DATA_W;

  localparam logic [CntW-1:0] FillLoad  = CntW'(FILL_CYC - 1);
  localparam logic [CntW-1:0] CompLoad  = CntW'(COMPUTE_CYC - 1);
  localparam logic [IDX_W:0]  DepthRows = (IDX_W+1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StFill, StCompute, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IDX_W:0]    rows_q, rows_d;
  logic [IDX_W:0]    num_q, num_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DinW-1:0]   din_q, din_d;
  logic              en_q, en_d;
  logic              write_q, write_d;
  logic              done_q, done_d;
  logic              beat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rows_d  = rows_q;
    num_d   = num_q;
    idx_d   = idx_q;
    din_d   = din_q;
    beat    = (state_q == StLoad) && S_VALID;

    // ABORT beats everything, including a final LOAD beat on the same edge.
    if (state_q != StIdle && ABORT) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
      din_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START && !ABORT) begin
            state_d = StLoad;
            cnt_d   = '0;
            rows_d  = '0;
            if (NUM_ROWS == '0 || {1'b0, NUM_ROWS} > DepthRows) begin
              num_d = DepthRows;
            end else begin
              num_d = {1'b0, NUM_ROWS};
            end
          end
        end
        StLoad: begin
          if (beat) begin
            idx_d  = rows_q[IDX_W-1:0];
            din_d  = S_DATA;
            rows_d = rows_q + 1'b1;
            if (rows_q + 1'b1 == num_q) begin
              state_d = StFill;
              cnt_d   = FillLoad;
            end
          end
        end
        StFill: begin
          if (cnt_q == '0) begin
            state_d = StCompute;
            cnt_d   = CompLoad;
            idx_d   = '0;
            din_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StCompute: begin
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    en_d    = (state_d != StIdle);
    write_d = (state_d == StLoad) || (state_d == StFill);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rows_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      din_q   <= '0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      en_q    <= en_d;
      write_q <= write_d;
      done_q  <= done_d;
    end
  end

  assign S_READY     = (state_q == StLoad);
  assign SA_EN       = en_q;
  assign SA_RF_EN    = en_q;
  assign BUSY        = en_q;
  assign SA_WRITE    = write_q;
  assign DONE        = done_q;
  assign SA_IDX      = idx_q;
  assign SA_DIN      = din_q;
  assign ROWS_LOADED = rows_q;

endmodule
